// File: rtl/hive_rbus_mstr_if.sv
// hive_rbus_mstr_if: request, response and rbus signals of the rbus initiator.
// master = initiator side, slave = host/register side.
interface hive_rbus_mstr_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    logic              req_vld_i;
    logic              req_rdy_o;
    logic [1:0]        req_op_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic [DATA_W-1:0] req_data_i;
    logic              rsp_vld_o;
    logic              rsp_rdy_i;
    logic [DATA_W-1:0] rsp_data_o;
    logic              rsp_err_o;
    logic              busy_o;
    logic [ADDR_W-1:0] rbus_addr_o;
    logic              rbus_wr_o;
    logic              rbus_rd_o;
    logic [DATA_W-1:0] rbus_wr_data_o;
    logic [DATA_W-1:0] rbus_rd_data_i;

    modport master (
        input  req_vld_i, req_op_i, req_addr_i, req_data_i,
        input  rsp_rdy_i, rbus_rd_data_i,
        output req_rdy_o, rsp_vld_o, rsp_data_o, rsp_err_o,
        output busy_o, rbus_addr_o, rbus_wr_o, rbus_rd_o,
        output rbus_wr_data_o
    );

    modport slave (
        output req_vld_i, req_op_i, req_addr_i, req_data_i,
        output rsp_rdy_i, rbus_rd_data_i,
        input  req_rdy_o, rsp_vld_o, rsp_data_o, rsp_err_o,
        input  busy_o, rbus_addr_o, rbus_wr_o, rbus_rd_o,
        input  rbus_wr_data_o
    );
endinterface

// File: rtl/hive_rbus_mstr.sv
// hive_rbus_mstr: single-outstanding rbus initiator (WRITE/READ/SET/CLR).
// Define HIVE_RBUS_MSTR_RMW_EN to build the read-modify-write datapath.
module hive_rbus_mstr #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    hive_rbus_mstr_if.master  bus
);
    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
`ifdef HIVE_RBUS_MSTR_RMW_EN
    localparam logic [1:0] OP_SET   = 2'd2;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_WR,
        S_RSP
    } state_t;

    state_t            state_q;
    logic [1:0]        op_q;
    logic [DATA_W-1:0] data_q;
    logic              req_rdy_q;
    logic              rsp_vld_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_err_q;
    logic              busy_q;
    logic [ADDR_W-1:0] addr_q;
    logic              wr_q;
    logic              rd_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              rd_path_d;

`ifdef HIVE_RBUS_MSTR_RMW_EN
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rmw_d;

    // Everything except WRITE needs the current register value first.
    assign rd_path_d = (bus.req_op_i != OP_WRITE);

    // Modified value built straight from the bus in the capture cycle.
    assign rmw_d = (op_q == OP_SET) ?
                   (bus.rbus_rd_data_i | data_q) :
                   (bus.rbus_rd_data_i & ~data_q);
`else
    // Without RMW only READ touches the read strobe.
    assign rd_path_d = (bus.req_op_i == OP_READ);
`endif

    // Transaction sequencer; every output is a register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            op_q       <= OP_WRITE;
            data_q     <= '0;
            req_rdy_q  <= 1'b1;
            rsp_vld_q  <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            busy_q     <= 1'b0;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            wr_data_q  <= '0;
`ifdef HIVE_RBUS_MSTR_RMW_EN
            rd_data_q  <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.req_vld_i) begin
                        op_q      <= bus.req_op_i;
                        data_q    <= bus.req_data_i;
                        addr_q    <= bus.req_addr_i;
                        req_rdy_q <= 1'b0;
                        busy_q    <= 1'b1;
                        if (rd_path_d) begin
                            rd_q    <= 1'b1;
                            state_q <= S_RD;
                        end else begin
                            wr_q      <= 1'b1;
                            wr_data_q <= bus.req_data_i;
                            state_q   <= S_WR;
                        end
                    end
                end
                S_RD: begin
                    rd_q    <= 1'b0;
                    state_q <= S_CAP;
                end
                S_CAP: begin
`ifdef HIVE_RBUS_MSTR_RMW_EN
                    if (op_q == OP_READ) begin
                        rsp_vld_q  <= 1'b1;
                        rsp_data_q <= bus.rbus_rd_data_i;
                        rsp_err_q  <= 1'b0;
                        state_q    <= S_RSP;
                    end else begin
                        rd_data_q <= bus.rbus_rd_data_i;
                        wr_q      <= 1'b1;
                        wr_data_q <= rmw_d;
                        state_q   <= S_WR;
                    end
`else
                    rsp_vld_q  <= 1'b1;
                    rsp_data_q <= bus.rbus_rd_data_i;
                    rsp_err_q  <= 1'b0;
                    state_q    <= S_RSP;
`endif
                end
                S_WR: begin
                    wr_q      <= 1'b0;
                    rsp_vld_q <= 1'b1;
                    state_q   <= S_RSP;
`ifdef HIVE_RBUS_MSTR_RMW_EN
                    rsp_err_q  <= 1'b0;
                    rsp_data_q <= (op_q == OP_WRITE) ?
                                  data_q : rd_data_q;
`else
                    rsp_err_q  <= (op_q != OP_WRITE);
                    rsp_data_q <= data_q;
`endif
                end
                S_RSP: begin
                    if (bus.rsp_rdy_i) begin
                        rsp_vld_q <= 1'b0;
                        req_rdy_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end
                default: begin
                    rd_q      <= 1'b0;
                    wr_q      <= 1'b0;
                    rsp_vld_q <= 1'b0;
                    req_rdy_q <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_rdy_o      = req_rdy_q;
    assign bus.rsp_vld_o      = rsp_vld_q;
    assign bus.rsp_data_o     = rsp_data_q;
    assign bus.rsp_err_o      = rsp_err_q;
    assign bus.busy_o         = busy_q;
    assign bus.rbus_addr_o    = addr_q;
    assign bus.rbus_wr_o      = wr_q;
    assign bus.rbus_rd_o      = rd_q;
    assign bus.rbus_wr_data_o = wr_data_q;
endmodule

// File: tb/tb_hive_rbus_mstr.sv
// tb_hive_rbus_mstr: directed + random requests against an op-level model.
// The register slave set is a simple array with a registered read path.
module tb_hive_rbus_mstr;
`ifdef HIVE_RBUS_MSTR_RMW_EN
    localparam bit RMW = 1'b1;
`else
    localparam bit RMW = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    hive_rbus_mstr_if #(.DATA_W(32), .ADDR_W(8)) bus ();

    hive_rbus_mstr #(.DATA_W(32), .ADDR_W(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Register slave set: data appears the cycle after the read strobe.
    logic [31:0] mem [256];
    logic        rd_hit;
    logic [7:0]  rd_addr;
    always @(posedge clk) begin
        rd_hit  <= bus.rbus_rd_o;
        rd_addr <= bus.rbus_addr_o;
        if (bus.rbus_wr_o)
            mem[bus.rbus_addr_o] <= bus.rbus_wr_data_o;
    end
    assign bus.rbus_rd_data_i = rd_hit ? mem[rd_addr] : 32'h0;

    // Expected register contents, kept per spec rules.
    logic [31:0] refm [256];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [1:0] op, input logic [7:0] a,
                         input logic [31:0] d, input int hold);
        bit          rmw_op, e_rd, e_wr, e_err;
        int          e_wr_cyc, e_lat;
        logic [31:0] old, e_wd, e_rsp;
        int          nrd, nwr, both, rd_cyc, wr_cyc, lat, rdy_hi, n;
        logic [7:0]  rd_a, wr_a;
        logic [31:0] wd, rsp_d, unstable;
        logic        rsp_e;

        rmw_op   = RMW && op[1];
        e_rd     = (op == 2'd1) || rmw_op;
        e_wr     = (op != 2'd1);
        e_wr_cyc = rmw_op ? 3 : 1;
        e_lat    = (op == 2'd1) ? 3 : (rmw_op ? 4 : 2);
        old      = refm[a];
        e_wd     = d;
        if (rmw_op && op == 2'd2) e_wd = old | d;
        if (rmw_op && op == 2'd3) e_wd = old & ~d;
        e_rsp    = e_rd ? old : d;
        e_err    = op[1] && !RMW;
        if (e_wr) refm[a] = e_wd;

        nrd = 0; nwr = 0; both = 0; rd_cyc = 0; wr_cyc = 0;
        lat = 0; rdy_hi = 0; n = 0; rd_a = 0; wr_a = 0; wd = 0;
        unstable = 0;

        @(negedge clk);
        bus.req_vld_i  = 1'b1;
        bus.req_op_i   = op;
        bus.req_addr_i = a;
        bus.req_data_i = d;
        while (!bus.req_rdy_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_rdy", {31'd0, bus.req_rdy_o}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_vld_i = 1'b0;
        chk("busy_c1", {31'd0, bus.busy_o}, 32'd1);

        for (int k = 1; k <= 30; k++) begin
            if (bus.rbus_rd_o) begin nrd++; rd_cyc = k; rd_a = bus.rbus_addr_o; end
            if (bus.rbus_wr_o) begin
                nwr++; wr_cyc = k;
                wr_a = bus.rbus_addr_o; wd = bus.rbus_wr_data_o;
            end
            if (bus.rbus_rd_o && bus.rbus_wr_o) both++;
            if (bus.req_rdy_o) rdy_hi++;
            if (bus.rsp_vld_o) begin lat = k; break; end
            @(negedge clk);
        end
        rsp_d = bus.rsp_data_o;
        rsp_e = bus.rsp_err_o;

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!bus.rsp_vld_o || bus.rsp_data_o !== rsp_d ||
                bus.rsp_err_o !== rsp_e) unstable++;
            if (bus.req_rdy_o) rdy_hi++;
            if (bus.rbus_rd_o) nrd++;
            if (bus.rbus_wr_o) nwr++;
        end
        bus.rsp_rdy_i = 1'b1;
        @(negedge clk);
        bus.rsp_rdy_i = 1'b0;

        chk("rsp_latency", lat, e_lat);
        chk("rsp_data", rsp_d, e_rsp);
        chk("rsp_err", {31'd0, rsp_e}, {31'd0, e_err});
        chk("rd_count", nrd, {31'd0, e_rd});
        chk("wr_count", nwr, {31'd0, e_wr});
        chk("no_overlap", both, 0);
        chk("rdy_low_busy", rdy_hi, 0);
        chk("hold_stable", unstable, 0);
        if (e_rd) begin
            chk("rd_cycle", rd_cyc, 1);
            chk("rd_addr", {24'd0, rd_a}, {24'd0, a});
        end
        if (e_wr) begin
            chk("wr_cycle", wr_cyc, e_wr_cyc);
            chk("wr_addr", {24'd0, wr_a}, {24'd0, a});
            chk("wr_data", wd, e_wd);
        end
        chk("post_vld", {31'd0, bus.rsp_vld_o}, 32'd0);
        chk("post_rdy", {31'd0, bus.req_rdy_o}, 32'd1);
        chk("post_busy", {31'd0, bus.busy_o}, 32'd0);
    endtask

    initial begin
        int s;
        bus.req_vld_i  = 1'b0;
        bus.req_op_i   = 2'd0;
        bus.req_addr_i = 8'd0;
        bus.req_data_i = 32'd0;
        bus.rsp_rdy_i  = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_req_rdy", {31'd0, bus.req_rdy_o}, 32'd1);
        chk("rst_rsp_vld", {31'd0, bus.rsp_vld_o}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("rst_strobes", {30'd0, bus.rbus_rd_o, bus.rbus_wr_o}, 32'd0);
        chk("rst_addr", {24'd0, bus.rbus_addr_o}, 32'd0);
        chk("rst_wdata", bus.rbus_wr_data_o, 32'd0);
        chk("rst_rsp_data", bus.rsp_data_o, 32'd0);
        chk("rst_rsp_err", {31'd0, bus.rsp_err_o}, 32'd0);
        rst = 1'b0;

        do_op(2'd0, 8'h05, 32'hDEADBEEF, 0);
        do_op(2'd0, 8'h03, 32'h0000A5A5, 0);
        do_op(2'd1, 8'h03, 32'h0, 10);
        do_op(2'd0, 8'h10, 32'h000000F0, 0);
        do_op(2'd2, 8'h10, 32'h0000000F, 0);
        do_op(2'd3, 8'h10, 32'h00000030, 1);
        do_op(2'd1, 8'h10, 32'h0, 0);

        // Reset in the middle of a read strobe.
        @(negedge clk);
        bus.req_vld_i  = 1'b1;
        bus.req_op_i   = 2'd1;
        bus.req_addr_i = 8'h03;
        @(posedge clk);
        @(negedge clk);
        bus.req_vld_i = 1'b0;
        chk("mid_rd_high", {31'd0, bus.rbus_rd_o}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rd_drop", {31'd0, bus.rbus_rd_o}, 32'd0);
        chk("mid_rdy", {31'd0, bus.req_rdy_o}, 32'd1);
        chk("mid_vld", {31'd0, bus.rsp_vld_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        s = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.rbus_rd_o || bus.rbus_wr_o || bus.rsp_vld_o ||
                !bus.req_rdy_o) s++;
        end
        chk("post_rst_quiet", s, 0);

        for (int i = 0; i < 16; i++)
            do_op(2'd0, i[7:0], $urandom, 0);
        for (int i = 0; i < 40; i++)
            do_op(2'($urandom_range(0, 3)), 8'($urandom_range(0, 15)),
                  $urandom, $urandom_range(0, 3));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
